// File: rtl/mips_data_mem.sv
// mips_data_mem: word-addressed data memory answering the MIPS_CPU load/store port.
// Ports: Clock, Reset (sync, active-high); addr/MemRead/MemWrite/wdata request in;
//        data (last read), Ready, DataValid, WriteAck, AccessErr status out.
module mips_data_mem #(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] data,
    output logic        Ready,
    output logic        DataValid,
    output logic        WriteAck,
    output logic        AccessErr
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];
    logic [0:0]    state;
    logic [AW-1:0] cnt;

    logic [31:0]   word_off;
    logic [AW-1:0] idx;
    logic          legal;
    logic          req;
    logic          rd_ok;
    logic          wr_ok;
    logic          err;

    // Subtraction result is only trusted once addr >= BASE_ADDR holds,
    // so addresses below the base never alias into the array.
    always_comb begin
        word_off = (addr - BASE_ADDR) >> 2;
        idx      = word_off[AW-1:0];
        legal    = (addr[1:0] == 2'b00)
                && (addr >= BASE_ADDR)
                && (word_off < 32'(DEPTH));
        req      = MemRead | MemWrite;
        rd_ok    = MemRead & ~MemWrite & legal;
        wr_ok    = MemWrite & ~MemRead & legal;
        err      = req & ((MemRead & MemWrite) | ~legal);
    end

    assign Ready = (state == IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            data      <= '0;
            DataValid <= 1'b0;
            WriteAck  <= 1'b0;
            AccessErr <= 1'b0;
        end else if (state == CLEAR) begin
            DataValid <= 1'b0;
            WriteAck  <= 1'b0;
            AccessErr <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= IDLE;
            end
        end else begin
            DataValid <= rd_ok;
            WriteAck  <= wr_ok;
            AccessErr <= err;
            if (rd_ok) begin
                data <= mem[idx];
            end
        end
    end

    // Array has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[idx] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// tb_mips_data_mem: directed, table-driven self-checking bench for mips_data_mem.
// Drives requests after each rising edge and checks outputs 1ns later.
module tb_mips_data_mem;

    logic        Clock;
    logic        Reset;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        Ready;
    logic        DataValid;
    logic        WriteAck;
    logic        AccessErr;

    int n_cmp = 0;
    int n_bad = 0;

    mips_data_mem dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .addr      (addr),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .wdata     (wdata),
        .data      (data),
        .Ready     (Ready),
        .DataValid (DataValid),
        .WriteAck  (WriteAck),
        .AccessErr (AccessErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        exp_dv;
        logic        exp_ack;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = wd;
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic dv, input logic ack, input logic er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
        v.exp_data = ed; v.exp_dv = dv; v.exp_ack = ack; v.exp_err = er;
        vecs.push_back(v);
    endtask

    // Counts cycles with Ready low after Reset drops; flags any pulse seen.
    task automatic wait_clear(input string name);
        int cyc;
        int pulses;
        cyc    = 0;
        pulses = 0;
        while (!Ready && cyc < 200) begin
            step();
            cyc++;
            if (!Ready && (DataValid || WriteAck || AccessErr)) pulses++;
        end
        chk({name, "_ready_low_cycles"}, 32'(cyc), 32'd64);
        chk({name, "_pulses_in_clear"}, 32'(pulses), 32'd0);
        chk({name, "_ready_after"}, {31'd0, Ready}, 32'd1);
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        Reset = 1'b1;
        step();
        chk("rst_data", data, 32'h0);
        chk("rst_ready", {31'd0, Ready}, 32'd0);
        chk("rst_pulses", {29'd0, DataValid, WriteAck, AccessErr}, 32'd0);

        // Store held during the whole sweep must be ignored.
        Reset = 1'b0;
        drive(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
        wait_clear("clr1");
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        //  rd    wr    addr       wdata         data          dv ack err
        add(1'b1, 1'b0, 32'h10,  32'h0,         32'h0,         1, 0, 0);
        add(1'b0, 1'b1, 32'h04,  32'hDEADBEEF,  32'h0,         0, 1, 0);
        add(1'b1, 1'b0, 32'h04,  32'h0,         32'hDEADBEEF,  1, 0, 0);
        add(1'b1, 1'b0, 32'h06,  32'h0,         32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 1'b0, 32'h100, 32'h0,         32'hDEADBEEF,  0, 0, 1);
        add(1'b0, 1'b1, 32'h102, 32'h5555_5555, 32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 1'b0, 32'h04,  32'h0,         32'hDEADBEEF,  1, 0, 0);
        add(1'b1, 1'b1, 32'h08,  32'h12345678,  32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 1'b0, 32'h08,  32'h0,         32'h0,         1, 0, 0);
        add(1'b0, 1'b1, 32'h00,  32'h11,        32'h0,         0, 1, 0);
        add(1'b0, 1'b1, 32'h04,  32'h22,        32'h0,         0, 1, 0);
        add(1'b0, 1'b1, 32'h08,  32'h33,        32'h0,         0, 1, 0);
        add(1'b1, 1'b0, 32'h00,  32'h0,         32'h11,        1, 0, 0);
        add(1'b1, 1'b0, 32'h04,  32'h0,         32'h22,        1, 0, 0);
        add(1'b1, 1'b0, 32'h08,  32'h0,         32'h33,        1, 0, 0);
        add(1'b0, 1'b0, 32'h04,  32'h9999,      32'h33,        0, 0, 0);
        add(1'b0, 1'b1, 32'hFC,  32'hA5A5_0001, 32'h33,        0, 1, 0);
        add(1'b1, 1'b0, 32'hFC,  32'h0,         32'hA5A5_0001, 1, 0, 0);
        add(1'b1, 1'b0, 32'h04,  32'h0,         32'h22,        1, 0, 0);
        add(1'b0, 1'b1, 32'h20,  32'h7777_7777, 32'h22,        0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
            step();
            chk({tag, "_data"}, data, vecs[i].exp_data);
            chk({tag, "_dv"}, {31'd0, DataValid}, {31'd0, vecs[i].exp_dv});
            chk({tag, "_ack"}, {31'd0, WriteAck}, {31'd0, vecs[i].exp_ack});
            chk({tag, "_err"}, {31'd0, AccessErr}, {31'd0, vecs[i].exp_err});
            chk({tag, "_ready"}, {31'd0, Ready}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("idle_pulses", {29'd0, DataValid, WriteAck, AccessErr}, 32'd0);

        // Reset with a store pending, then again at clear count 20.
        drive(1'b0, 1'b1, 32'h30, 32'hBAD0_BAD0);
        Reset = 1'b1;
        step();
        chk("rst2_data", data, 32'h0);
        chk("rst2_ready", {31'd0, Ready}, 32'd0);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) step();
        Reset = 1'b1;
        step();
        chk("rst3_ready", {31'd0, Ready}, 32'd0);
        Reset = 1'b0;
        wait_clear("clr2");

        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
            step();
            chk($sformatf("zero_w%0d", i), data, 32'h0);
            chk($sformatf("zero_dv%0d", i), {31'd0, DataValid}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
